// File: rtl/md_defs_pkg.sv
// Shared definitions for the multiply/divide unit and the decoder that drives it.
package md_defs;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } md_state_e;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at
// issue into a pending register and committed after a fixed latency.
module md_unit
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Start,
  input  logic [2:0]  MdOp,
  input  logic        Cancel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned N_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW    = $clog2(N_MAX + 1);

  md_state_e      r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [31:0]    r_hi, w_hi_nxt;
  logic [31:0]    r_lo, w_lo_nxt;
  logic [63:0]    r_pend, w_pend_nxt;
  logic           r_skip, w_skip_nxt;

  logic [63:0]    w_a_sx, w_b_sx, w_mul_s, w_mul_u;
  logic [31:0]    w_div_b, w_a_abs, w_b_abs, w_q_mag, w_r_mag;
  logic [31:0]    w_q_s, w_r_s, w_q_u, w_r_u;

  // Arithmetic datapath; a zero divisor is replaced by 1 so no X reaches the
  // pending register (that result is never committed anyway).
  always_comb begin
    w_a_sx  = {{32{A[31]}}, A};
    w_b_sx  = {{32{B[31]}}, B};
    w_mul_s = w_a_sx * w_b_sx;
    w_mul_u = {32'd0, A} * {32'd0, B};
    w_div_b = (B == '0) ? 32'd1 : B;
    w_q_u   = A / w_div_b;
    w_r_u   = A % w_div_b;
    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. 0x80000000 / -1 wraps to 0x80000000.
    w_a_abs = A[31] ? (~A + 32'd1) : A;
    w_b_abs = w_div_b[31] ? (~w_div_b + 32'd1) : w_div_b;
    w_q_mag = w_a_abs / w_b_abs;
    w_r_mag = w_a_abs % w_b_abs;
    w_q_s   = (A[31] ^ w_div_b[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
    w_r_s   = A[31] ? (~w_r_mag + 32'd1) : w_r_mag;
  end

  // Control FSM: issue, countdown, commit; Cancel overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_pend_nxt  = r_pend;
    w_skip_nxt  = r_skip;
    if (Cancel) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_pend_nxt  = '0;
      w_skip_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            case (MdOp)
              MD_MULT: begin
                w_pend_nxt  = w_mul_s;
                w_cnt_nxt   = CW'(MULT_CYCLES);
                w_skip_nxt  = 1'b0;
                w_state_nxt = ST_BUSY;
              end
              MD_MULTU: begin
                w_pend_nxt  = w_mul_u;
                w_cnt_nxt   = CW'(MULT_CYCLES);
                w_skip_nxt  = 1'b0;
                w_state_nxt = ST_BUSY;
              end
              MD_DIV: begin
                w_pend_nxt  = {w_r_s, w_q_s};
                w_cnt_nxt   = CW'(DIV_CYCLES);
                w_skip_nxt  = (B == '0);
                w_state_nxt = ST_BUSY;
              end
              MD_DIVU: begin
                w_pend_nxt  = {w_r_u, w_q_u};
                w_cnt_nxt   = CW'(DIV_CYCLES);
                w_skip_nxt  = (B == '0);
                w_state_nxt = ST_BUSY;
              end
              MD_MTHI: w_hi_nxt = A;
              MD_MTLO: w_lo_nxt = A;
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          if (r_cnt == CW'(1)) begin
            if (!r_skip) begin
              w_hi_nxt = r_pend[63:32];
              w_lo_nxt = r_pend[31:0];
            end
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and architectural registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_pend  <= '0;
      r_skip  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_pend  <= w_pend_nxt;
      r_skip  <= w_skip_nxt;
    end
  end

  assign Busy = (r_state == ST_BUSY);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
